// File: rtl/pulse_sync_gen.sv
// Multi-channel radar pulse sync generator: one delayed, programmable-width pulse
// per channel each frame, with shadowed configuration applied at frame boundaries.
module pulse_sync_gen #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned PERIOD = 100000,
  parameter int unsigned MODE   = 0
) (
  input  logic                    sysclk,
  input  logic                    btn,
  input  logic                    trig_in,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       cfg_en,
  input  logic [NUM_CH*CNT_W-1:0] cfg_delay,
  input  logic [NUM_CH*CNT_W-1:0] cfg_width,
  output logic [NUM_CH-1:0]       ja,
  output logic                    frame_sync,
  output logic                    cfg_pending,
  output logic [15:0]             frame_cnt
);

  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] T_MAX  = '1;

  logic                    trig_s1_q, trig_s1_d;
  logic                    trig_s2_q, trig_s2_d;
  logic                    trig_s3_q, trig_s3_d;
  logic [CNT_W-1:0]        t_q, t_d, t_cur;
  logic                    fs;
  logic [NUM_CH-1:0]       act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic [NUM_CH*CNT_W-1:0] act_delay_q, act_delay_d, act_width_q, act_width_d;
  logic [NUM_CH*CNT_W-1:0] pend_delay_q, pend_delay_d, pend_width_q, pend_width_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [NUM_CH-1:0]       ja_q, ja_d;
  logic                    frame_sync_q, frame_sync_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  always_comb begin
    trig_s1_d    = trig_in;
    trig_s2_d    = trig_s1_q;
    trig_s3_d    = trig_s2_q;
    fs           = 1'b0;
    t_cur        = t_q;
    t_d          = t_q;
    act_en_d     = act_en_q;
    act_delay_d  = act_delay_q;
    act_width_d  = act_width_q;
    pend_en_d    = pend_en_q;
    pend_delay_d = pend_delay_q;
    pend_width_d = pend_width_q;
    pend_valid_d = pend_valid_q;
    ja_d         = '0;
    frame_sync_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (MODE == 0) begin
      fs    = (t_q == '0);
      t_cur = t_q;
      t_d   = (t_q == T_LAST) ? '0 : t_q + CNT_W'(1);
    end else begin
      fs    = trig_s2_q & ~trig_s3_q;
      t_cur = fs ? '0 : t_q;
      t_d   = fs ? CNT_W'(1) : ((t_q == T_MAX) ? t_q : t_q + CNT_W'(1));
    end

    if (fs && pend_valid_q) begin
      act_en_d     = pend_en_q;
      act_delay_d  = pend_delay_q;
      act_width_d  = pend_width_q;
      pend_valid_d = 1'b0;
    end
    // A load coinciding with FS lands in pending after the old pending was applied.
    if (cfg_load) begin
      pend_en_d    = cfg_en;
      pend_delay_d = cfg_delay;
      pend_width_d = cfg_width;
      pend_valid_d = 1'b1;
    end

    // Compare against the config taking effect this cycle so delay=0 fires right after FS.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ja_d[i] = act_en_d[i]
             && (t_cur >= act_delay_d[i*CNT_W +: CNT_W])
             && ({1'b0, t_cur} < ({1'b0, act_delay_d[i*CNT_W +: CNT_W]}
                                + {1'b0, act_width_d[i*CNT_W +: CNT_W]}));
    end

    frame_sync_d = fs;
    if (fs) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge sysclk) begin
    if (btn) begin
      trig_s1_q    <= 1'b0;
      trig_s2_q    <= 1'b0;
      trig_s3_q    <= 1'b0;
      t_q          <= '0;
      act_en_q     <= '0;
      act_delay_q  <= '0;
      act_width_q  <= '0;
      pend_en_q    <= '0;
      pend_delay_q <= '0;
      pend_width_q <= '0;
      pend_valid_q <= 1'b0;
      ja_q         <= '0;
      frame_sync_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      trig_s1_q    <= trig_s1_d;
      trig_s2_q    <= trig_s2_d;
      trig_s3_q    <= trig_s3_d;
      t_q          <= t_d;
      act_en_q     <= act_en_d;
      act_delay_q  <= act_delay_d;
      act_width_q  <= act_width_d;
      pend_en_q    <= pend_en_d;
      pend_delay_q <= pend_delay_d;
      pend_width_q <= pend_width_d;
      pend_valid_q <= pend_valid_d;
      ja_q         <= ja_d;
      frame_sync_q <= frame_sync_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign ja          = ja_q;
  assign frame_sync  = frame_sync_q;
  assign cfg_pending = pend_valid_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
